// File: rtl/svm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | svm_pkg : shared types and helpers for the SVM MAC sequencer      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package svm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// +------------------------------------------------------------------+
// | delay_line : DEPTH-stage shift register with synchronous flush    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/svm_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | svm_mac_sequencer : walks inst x sv x feat, issues MAC terms and  |
// | result write strobes. Rev 1.0                                     |
// +------------------------------------------------------------------+
module svm_mac_sequencer
    import svm_pkg::*;
#(
    parameter int NUM_FEAT = 2,
    parameter int NUM_SV   = 3,
    parameter int NUM_INST = 2,
    parameter int MAC_LAT  = 2,
    localparam int IW = idx_w(NUM_INST),
    localparam int SW = idx_w(NUM_SV),
    localparam int FW = idx_w(NUM_FEAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          op_ready_i,
    output logic [IW-1:0] inst_idx_o,
    output logic [SW-1:0] sv_idx_o,
    output logic [FW-1:0] feat_idx_o,
    output logic          mac_en_o,
    output logic          mac_clr_o,
    output logic          mac_last_o,
    output logic          res_we_o,
    output logic [IW-1:0] res_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [SW-1:0] sv_q, sv_d;
    logic [FW-1:0] feat_q, feat_d;

    logic w_feat_last, w_sv_last, w_inst_last;
    logic w_cancel, w_final_res;
    logic [IW:0] w_pipe_in, w_pipe_out;

    assign w_feat_last = (feat_q == FW'(NUM_FEAT - 1));
    assign w_sv_last   = (sv_q   == SW'(NUM_SV - 1));
    assign w_inst_last = (inst_q == IW'(NUM_INST - 1));
    assign w_cancel    = abort_i && (state_q != S_IDLE);
    assign w_final_res = (state_q == S_DRAIN) && res_we_o && (res_idx_o == IW'(NUM_INST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            sv_q    <= '0;
            feat_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            sv_q    <= sv_d;
            feat_q  <= feat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        sv_d    = sv_q;
        feat_d  = feat_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (op_ready_i) begin
                    if (w_feat_last) begin
                        feat_d = '0;
                        if (w_sv_last) begin
                            sv_d = '0;
                            if (w_inst_last) begin
                                inst_d  = '0;
                                state_d = S_DRAIN;
                            end else begin
                                inst_d = inst_q + IW'(1);
                            end
                        end else begin
                            sv_d = sv_q + SW'(1);
                        end
                    end else begin
                        feat_d = feat_q + FW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_final_res) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Cancellation overrides any transition computed above.
        if (w_cancel) begin
            state_d = S_IDLE;
            inst_d  = '0;
            sv_d    = '0;
            feat_d  = '0;
        end
    end

    always_comb begin
        mac_en_o   = (state_q == S_RUN) && op_ready_i;
        mac_clr_o  = mac_en_o && (sv_q == '0) && (feat_q == '0);
        mac_last_o = mac_en_o && w_sv_last && w_feat_last;
        busy_o     = (state_q != S_IDLE);
        done_o     = w_final_res && !abort_i;
        inst_idx_o = inst_q;
        sv_idx_o   = sv_q;
        feat_idx_o = feat_q;
    end

    assign w_pipe_in = {mac_en_o & mac_last_o, inst_q};

    delay_line #(
        .WIDTH (IW + 1),
        .DEPTH (MAC_LAT)
    ) u_res_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (w_cancel),
        .din_i   (w_pipe_in),
        .dout_o  (w_pipe_out)
    );

    assign res_we_o  = w_pipe_out[IW];
    assign res_idx_o = w_pipe_out[IW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_svm_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_svm_mac_sequencer : directed + random bench for the sequencer  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_svm_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, op_ready = 1'b0;
    bit   sel = 1'b0;

    always #5 clk = ~clk;

    // Default-size instance (A) and fully degenerate instance (B)
    logic       a_inst, a_feat, a_en, a_clr, a_last, a_we, a_ridx, a_busy, a_done;
    logic [1:0] a_sv;
    logic       b_inst, b_sv, b_feat, b_en, b_clr, b_last, b_we, b_ridx, b_busy, b_done;

    svm_mac_sequencer u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start & ~sel),
        .abort_i    (abort & ~sel),
        .op_ready_i (op_ready & ~sel),
        .inst_idx_o (a_inst),
        .sv_idx_o   (a_sv),
        .feat_idx_o (a_feat),
        .mac_en_o   (a_en),
        .mac_clr_o  (a_clr),
        .mac_last_o (a_last),
        .res_we_o   (a_we),
        .res_idx_o  (a_ridx),
        .busy_o     (a_busy),
        .done_o     (a_done)
    );

    svm_mac_sequencer #(
        .NUM_FEAT (1),
        .NUM_SV   (1),
        .NUM_INST (1),
        .MAC_LAT  (1)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start & sel),
        .abort_i    (abort & sel),
        .op_ready_i (op_ready & sel),
        .inst_idx_o (b_inst),
        .sv_idx_o   (b_sv),
        .feat_idx_o (b_feat),
        .mac_en_o   (b_en),
        .mac_clr_o  (b_clr),
        .mac_last_o (b_last),
        .res_we_o   (b_we),
        .res_idx_o  (b_ridx),
        .busy_o     (b_busy),
        .done_o     (b_done)
    );

    logic [31:0] o_inst, o_sv, o_feat, o_ridx;
    logic        o_en, o_clr, o_last, o_we, o_busy, o_done;
    assign o_inst = sel ? 32'(b_inst) : 32'(a_inst);
    assign o_sv   = sel ? 32'(b_sv)   : 32'(a_sv);
    assign o_feat = sel ? 32'(b_feat) : 32'(a_feat);
    assign o_ridx = sel ? 32'(b_ridx) : 32'(a_ridx);
    assign o_en   = sel ? b_en   : a_en;
    assign o_clr  = sel ? b_clr  : a_clr;
    assign o_last = sel ? b_last : a_last;
    assign o_we   = sel ? b_we   : a_we;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;

    int errs = 0, checks = 0;
    int cyc = 0, t0 = 0, done_rel = -1, first_issue_rel = -1;
    int NI = 2, NS = 3, NF = 2, L = 2;

    // Reference model: run flag, count of terms issued, pending result writes
    bit act = 1'b0;
    int k = 0;
    int q_due[$];
    int q_idx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - t0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   32'(o_en),   0);
        chk({tag, "_clr"},  32'(o_clr),  0);
        chk({tag, "_last"}, 32'(o_last), 0);
        chk({tag, "_we"},   32'(o_we),   0);
        chk({tag, "_ridx"}, o_ridx,      0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_inst"}, o_inst,      0);
        chk({tag, "_sv"},   o_sv,        0);
        chk({tag, "_feat"}, o_feat,      0);
    endtask

    task automatic set_cfg(input bit s);
        sel = s;
        if (s) begin NI = 1; NS = 1; NF = 1; L = 1; end
        else   begin NI = 2; NS = 3; NF = 2; L = 2; end
    endtask

    task automatic begin_test();
        t0 = cyc;
        done_rel = -1;
        first_issue_rel = -1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model
    task automatic cycle(input bit s, input bit a, input bit r);
        int  T, P, ei, es, ef, eridx;
        bit  inrun, issue, eclr, elast, ewe, edone;
        @(negedge clk);
        rst = 1'b0; start = s; abort = a; op_ready = r;
        #1;
        T = NI * NS * NF;
        P = NS * NF;
        inrun = act && (k < T);
        issue = inrun && r;
        ei = inrun ? k / P : 0;
        es = inrun ? (k / NF) % NS : 0;
        ef = inrun ? k % NF : 0;
        eclr  = issue && (k % P == 0);
        elast = issue && (k % P == P - 1);
        ewe = 1'b0; eridx = 0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            ewe = 1'b1; eridx = q_idx[0];
            void'(q_due.pop_front());
            void'(q_idx.pop_front());
        end
        edone = ewe && (eridx == NI - 1) && act && !a;

        chk("mac_en",   32'(o_en),   32'(issue));
        chk("mac_clr",  32'(o_clr),  32'(eclr));
        chk("mac_last", 32'(o_last), 32'(elast));
        chk("inst_idx", o_inst, ei);
        chk("sv_idx",   o_sv,   es);
        chk("feat_idx", o_feat, ef);
        chk("res_we",   32'(o_we),   32'(ewe));
        chk("busy",     32'(o_busy), 32'(act));
        chk("done",     32'(o_done), 32'(edone));
        if (ewe || !act) chk("res_idx", o_ridx, eridx);

        if (o_done === 1'b1) done_rel = cyc - t0;
        if (o_en === 1'b1 && first_issue_rel < 0) first_issue_rel = cyc - t0;

        if (act && a) begin
            act = 1'b0; k = 0;
            q_due.delete(); q_idx.delete();
        end else if (act) begin
            if (issue) begin
                if (elast) begin
                    q_due.push_back(cyc + L);
                    q_idx.push_back(ei);
                end
                k++;
            end
            if (edone) act = 1'b0;
        end else if (s) begin
            act = 1'b1; k = 0;
        end
        cyc++;
    endtask

    task automatic mid_reset();
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        act = 1'b0; k = 0;
        q_due.delete(); q_idx.delete();
    endtask

    initial begin
        #2 chk_all_zero("reset");
        set_cfg(1'b0);

        // Uninterrupted run
        begin_test();
        cycle(1, 0, 1);
        repeat (16) cycle(0, 0, 1);
        chk("t1_first_issue", first_issue_rel, 1);
        chk("t1_done_cycle", done_rel, 14);

        // Operand stall for three cycles
        begin_test();
        for (int i = 0; i < 20; i++) cycle(i == 0, 0, !(i >= 3 && i <= 5));
        chk("t2_done_cycle", done_rel, 17);

        // Start while busy is ignored; back-to-back run right after done
        begin_test();
        for (int i = 0; i < 32; i++) cycle(i == 0 || i == 5 || i == 15, 0, 1);
        chk("t3_second_done", done_rel, 29);

        // Abort after first instance's last term
        begin_test();
        for (int i = 0; i < 16; i++) cycle(i == 0, i == 7, 1);
        chk("t4_no_done", done_rel, -1);

        // Asynchronous reset mid-run
        begin_test();
        for (int i = 0; i < 5; i++) cycle(i == 0, 0, 1);
        mid_reset();
        for (int i = 0; i < 16; i++) cycle(0, 0, 1);
        chk("t5_no_done", done_rel, -1);

        // Randomized runs
        repeat (6) begin
            begin_test();
            for (int i = 0; i < 40; i++)
                cycle(i == 0 || $urandom_range(0, 15) == 0,
                      $urandom_range(0, 49) == 0,
                      $urandom_range(0, 3) != 0);
            repeat (30) cycle(0, 0, 1);
        end

        // Degenerate single-term configuration
        set_cfg(1'b1);
        begin_test();
        cycle(1, 0, 1);
        repeat (4) cycle(0, 0, 1);
        chk("t7_first_issue", first_issue_rel, 1);
        chk("t7_done_cycle", done_rel, 2);

        begin_test();
        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0);
        repeat (10) cycle(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svm_mac_sequencer.md
# svm_mac_sequencer

Sequences the shared multiply-accumulate datapath of the SVM classifier. On `start` it walks instance × support-vector × feature index space and issues one MAC term per cycle when operands are available. It marks the first and last term of each instance's accumulation. It emits a result write strobe with the instance index once the MAC pipeline has produced that instance's sum, and it sits between the top-level control and the operand memories, MAC and result register bank.

## Interface
- `NUM_FEAT`, 2, features per vector
- `NUM_SV`, 3, support vectors
- `NUM_INST`, 2, instances classified per run
- `MAC_LAT`, 2, cycles from term issue to accumulator update visible at MAC output; must be ≥1
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `abort`  in  1  synchronous cancel of a run in progress
- `op_ready`  in  1  operand memories have data for current indices
- `inst_idx`  out  IW=max(1,$clog2(NUM_INST))  current instance address
- `sv_idx`  out  SW=max(1,$clog2(NUM_SV))  current support-vector address
- `feat_idx`  out  FW=max(1,$clog2(NUM_FEAT))  current feature address
- `mac_en`  out  1  issue one term this cycle
- `mac_clr`  out  1  with `mac_en`: load accumulator with product instead of adding
- `mac_last`  out  1  with `mac_en`: final term of current instance
- `res_we`  out  1  MAC output holds finished sum for `res_idx`
- `res_idx`  out  IW  instance index of the result being written
- `busy`  out  1  run in progress (RUN or DRAIN)
- `done`  out  1  one-cycle pulse, coincident with the final `res_we`

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: all indices 0. `start`=1 → RUN. `start` is ignored in RUN and DRAIN.
- RUN, `op_ready`=1:
  - `mac_en`=1.
  - `mac_clr`=1 iff `sv_idx`=0 and `feat_idx`=0.
  - `mac_last`=1 iff `sv_idx`=NUM_SV-1 and `feat_idx`=NUM_FEAT-1.
  - Indices advance feature-fastest: feat wraps NUM_FEAT-1→0 and increments sv; sv wraps NUM_SV-1→0 and increments inst.
  - Issue of the term with inst=NUM_INST-1 and `mac_last` → DRAIN; indices return to 0.
- RUN, `op_ready`=0: `mac_en`/`mac_clr`/`mac_last`=0, indices held. The delay pipeline keeps advancing, so stalls insert bubbles and never freeze in-flight terms.
- Result path: MAC_LAT-stage shift register of {`mac_en`&`mac_last`, `inst_idx`}. Its output drives `res_we`/`res_idx` (registered).
- DRAIN: no issues. Leaves to IDLE in the cycle the final `res_we` is asserted, with `done`=1 that cycle.
- `abort`=1 in RUN/DRAIN: next state IDLE, indices 0, delay pipeline flushed (no further `res_we`), no `done`. `abort` has no effect in IDLE.
- `abort` wins over every other transition in the same cycle.
- Reset: state IDLE, indices 0, pipeline cleared. Every output is 0 (`res_idx` 0, `busy` 0, `done` 0). Reset mid-run discards the run with no `done`.
- `busy` = (state≠IDLE), registered from state.

## Timing
- `start` high at edge 0 → RUN in cycle 1; first term issues in cycle 1 if `op_ready`.
- With no stalls, terms issue in cycles 1..T, where T=NUM_INST·NUM_SV·NUM_FEAT.
- `res_we` for instance i occurs MAC_LAT cycles after the cycle in which its `mac_last` issued.
- `done` asserts in cycle T+MAC_LAT, plus one cycle per stall. `busy` is high cycles 1..T+MAC_LAT.
- Back-to-back runs: `start` is accepted in the first IDLE cycle after `done`.
- Degenerate sizes (any NUM_*=1): the wrap logic still applies. For NUM_SV=NUM_FEAT=1, every issue carries both `mac_clr` and `mac_last`.

## Structure
- Package `svm_pkg`:
  - state enum `seq_state_t`.
  - `idx_w(n)` function returning max(1,$clog2(n)).
- Sub-module `delay_line #(WIDTH, DEPTH)`:
  - async-reset shift register with synchronous `flush`.
  - used for the {last, inst} pipeline.

## Test plan
- Defaults, `op_ready`=1, `start` at cycle 0:
  - issues in cycles 1–12.
  - `mac_clr` at cycles 1 and 7; `mac_last` at cycles 6 and 12.
  - `res_we` with idx 0 at cycle 8 and idx 1 at cycle 14; `done` at cycle 14; `busy` low at cycle 15.
- Defaults, `op_ready` low cycles 3–5:
  - indices held at (0,1,0) throughout.
  - `res_we` idx 0 at 11, idx 1 at 17, `done` at 17.
- `start` pulsed at cycles 0 and 5: the second pulse is ignored. A new `start` in cycle 15 begins a second run with first issue in cycle 16.
- `abort` at cycle 7 (after `mac_last` of inst 0):
  - `res_we` for idx 0 does not occur at cycle 8.
  - IDLE at cycle 8 with no `done` and all outputs 0.
- `rst` asserted asynchronously mid-cycle 4: outputs drop to 0 immediately; no `res_we` or `done` until a fresh `start`.
- NUM_INST=1, NUM_SV=1, NUM_FEAT=1, MAC_LAT=1: single issue at cycle 1 carrying `mac_clr` and `mac_last`; `res_we` idx 0 and `done` at cycle 2.
